// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_arbiter
//  Description : Arbitrates icache / dcache line requests onto a single
//                burst physical-memory port. Each 256-bit line moves as four
//                64-bit beats; read beats are reassembled and returned with a
//                one-cycle response pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module pmem_arbiter (
    input  logic         clk,
    input  logic         rst,

    input  logic         i_read,
    input  logic [31:0]  i_address,
    output logic [255:0] i_rdata,
    output logic         i_resp,

    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_address,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,

    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [63:0]  pmem_wdata,
    input  logic [63:0]  pmem_rdata,
    input  logic         pmem_resp
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_I_RD = 3'd1;
    localparam logic [2:0] c_D_RD = 3'd2;
    localparam logic [2:0] c_D_WR = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    // Line-aligned address: the low five bits select bytes within a line.
    localparam logic [31:0] c_LINE_MASK = 32'hFFFF_FFE0;

    logic [2:0]   r_state_q,   w_state_d;
    // Burst state that was granted; selects the responder while in DONE.
    logic [2:0]   r_owner_q,   w_owner_d;
    logic [1:0]   r_beat_q,    w_beat_d;
    logic [31:0]  r_addr_q,    w_addr_d;
    logic [255:0] r_wbuf_q,    w_wbuf_d;
    // Only beats 0..2 are buffered; beat 3 goes straight into the port register.
    logic [191:0] r_lbuf_q,    w_lbuf_d;
    // Separate per-port result registers keep each port's last line stable.
    logic [255:0] r_i_rdata_q, w_i_rdata_d;
    logic [255:0] r_d_rdata_q, w_d_rdata_d;

    logic         w_in_burst;
    logic         w_last_beat;

    assign w_in_burst  = (r_state_q == c_I_RD) || (r_state_q == c_D_RD) ||
                         (r_state_q == c_D_WR);
    assign w_last_beat = w_in_burst && pmem_resp && (r_beat_q == 2'd3);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= c_IDLE;
            r_owner_q   <= c_IDLE;
            r_beat_q    <= 2'd0;
            r_addr_q    <= 32'd0;
            r_wbuf_q    <= 256'd0;
            r_lbuf_q    <= 192'd0;
            r_i_rdata_q <= 256'd0;
            r_d_rdata_q <= 256'd0;
        end else begin
            r_state_q   <= w_state_d;
            r_owner_q   <= w_owner_d;
            r_beat_q    <= w_beat_d;
            r_addr_q    <= w_addr_d;
            r_wbuf_q    <= w_wbuf_d;
            r_lbuf_q    <= w_lbuf_d;
            r_i_rdata_q <= w_i_rdata_d;
            r_d_rdata_q <= w_d_rdata_d;
        end
    end

    // Next-state: fixed-priority grant from IDLE, leave a burst on its 4th beat.
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_IDLE: begin
                if (d_write)     w_state_d = c_D_WR;
                else if (d_read) w_state_d = c_D_RD;
                else if (i_read) w_state_d = c_I_RD;
            end
            c_I_RD, c_D_RD, c_D_WR: begin
                if (w_last_beat) w_state_d = c_DONE;
            end
            c_DONE:  w_state_d = c_IDLE;
            default: w_state_d = c_IDLE;
        endcase
    end

    // Datapath: latch request at grant, count beats, assemble read lines.
    always_comb begin
        w_owner_d   = r_owner_q;
        w_beat_d    = r_beat_q;
        w_addr_d    = r_addr_q;
        w_wbuf_d    = r_wbuf_q;
        w_lbuf_d    = r_lbuf_q;
        w_i_rdata_d = r_i_rdata_q;
        w_d_rdata_d = r_d_rdata_q;

        if ((r_state_q == c_IDLE) && (w_state_d != c_IDLE)) begin
            w_owner_d = w_state_d;
            w_beat_d  = 2'd0;
            w_addr_d  = ((w_state_d == c_I_RD) ? i_address : d_address) & c_LINE_MASK;
            w_wbuf_d  = d_wdata;
        end else if (w_in_burst && pmem_resp) begin
            w_beat_d = r_beat_q + 2'd1;
            if (r_state_q != c_D_WR) begin
                case (r_beat_q)
                    2'd0: w_lbuf_d[63:0]    = pmem_rdata;
                    2'd1: w_lbuf_d[127:64]  = pmem_rdata;
                    2'd2: w_lbuf_d[191:128] = pmem_rdata;
                    default: begin
                        if (r_state_q == c_I_RD) w_i_rdata_d = {pmem_rdata, r_lbuf_q};
                        else                     w_d_rdata_d = {pmem_rdata, r_lbuf_q};
                    end
                endcase
            end
        end
    end

    // Outputs: decoded purely from registered state, never from pmem inputs.
    always_comb begin
        pmem_read    = (r_state_q == c_I_RD) || (r_state_q == c_D_RD);
        pmem_write   = (r_state_q == c_D_WR);
        pmem_address = w_in_burst ? r_addr_q : 32'd0;
        pmem_wdata   = 64'd0;
        if (r_state_q == c_D_WR) begin
            case (r_beat_q)
                2'd0:    pmem_wdata = r_wbuf_q[63:0];
                2'd1:    pmem_wdata = r_wbuf_q[127:64];
                2'd2:    pmem_wdata = r_wbuf_q[191:128];
                default: pmem_wdata = r_wbuf_q[255:192];
            endcase
        end
        i_resp  = (r_state_q == c_DONE) && (r_owner_q == c_I_RD);
        d_resp  = (r_state_q == c_DONE) && (r_owner_q != c_I_RD);
        i_rdata = r_i_rdata_q;
        d_rdata = r_d_rdata_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pmem_arbiter
//  Description : Directed self-checking bench for pmem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pmem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] Q1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] Q2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] Q3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] Q4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] WB = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] WC = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] WD = 64'hDDDD_DDDD_DDDD_DDDD;
    localparam logic [63:0] R1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] R2 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] R3 = 64'h0F0F_0F0F_F0F0_F0F0;
    localparam logic [63:0] R4 = 64'h5A5A_A5A5_3C3C_C3C3;
    localparam logic [63:0] S1 = 64'h1000_0000_0000_0001;
    localparam logic [63:0] S2 = 64'h2000_0000_0000_0002;
    localparam logic [63:0] S3 = 64'h3000_0000_0000_0003;
    localparam logic [63:0] S4 = 64'h4000_0000_0000_0004;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    pmem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic resp, input logic [63:0] data);
        pmem_resp  = resp;
        pmem_rdata = data;
        tick();
    endtask

    initial begin
        rst = 1'b1; i_read = 1'b0; i_address = 32'd0;
        d_read = 1'b0; d_write = 1'b0; d_address = 32'd0; d_wdata = 256'd0;
        pmem_rdata = 64'd0; pmem_resp = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_pmem_read",  pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_addr",  pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_i_resp",     i_resp, 0);
        chk("rst_d_resp",     d_resp, 0);
        chk("rst_i_rdata",    i_rdata, 0);
        chk("rst_d_rdata",    d_rdata, 0);
        rst = 1'b0;
        tick();

        // ---------------- icache fill, latency 1 ----------------
        i_read = 1'b1; i_address = 32'h0000_0064;
        tick();
        chk("ifill_pmem_read", pmem_read, 1);
        chk("ifill_pmem_write", pmem_write, 0);
        chk("ifill_addr", pmem_address, 32'h0000_0060);
        i_address = 32'hFFFF_FFFF;
        step(1'b0, JUNK);
        step(1'b1, Q1);
        step(1'b1, Q2);
        step(1'b1, Q3);
        chk("ifill_resp_early", i_resp, 0);
        chk("ifill_addr_held", pmem_address, 32'h0000_0060);
        step(1'b1, Q4);
        chk("ifill_i_resp", i_resp, 1);
        chk("ifill_pmem_read_drop", pmem_read, 0);
        chk("ifill_i_rdata", i_rdata, {Q4, Q3, Q2, Q1});
        i_read = 1'b0;
        step(1'b0, JUNK);
        chk("ifill_resp_one_cycle", i_resp, 0);
        chk("ifill_rdata_held", i_rdata, {Q4, Q3, Q2, Q1});

        // ---------------- dcache writeback ----------------
        d_write = 1'b1; d_address = 32'h1234_567F; d_wdata = {WD, WC, WB, WA};
        tick();
        chk("wb_pmem_write", pmem_write, 1);
        chk("wb_pmem_read", pmem_read, 0);
        chk("wb_addr", pmem_address, 32'h1234_5660);
        chk("wb_beat0", pmem_wdata, WA);
        d_wdata = {4{JUNK}};
        step(1'b1, JUNK);
        chk("wb_beat1", pmem_wdata, WB);
        step(1'b0, JUNK);
        chk("wb_beat1_hold", pmem_wdata, WB);
        step(1'b1, JUNK);
        chk("wb_beat2", pmem_wdata, WC);
        step(1'b1, JUNK);
        chk("wb_beat3", pmem_wdata, WD);
        step(1'b1, JUNK);
        chk("wb_d_resp", d_resp, 1);
        chk("wb_i_resp", i_resp, 0);
        chk("wb_write_drop", pmem_write, 0);
        d_write = 1'b0;
        step(1'b0, JUNK);
        chk("wb_d_resp_one_cycle", d_resp, 0);

        // ---------------- contention, then gapped icache beats ----------------
        i_read = 1'b1; i_address = 32'h0000_3000;
        d_read = 1'b1; d_address = 32'h0000_2000;
        tick();
        chk("cont_d_first_addr", pmem_address, 32'h0000_2000);
        step(1'b1, R1);
        step(1'b1, R2);
        step(1'b1, R3);
        step(1'b1, R4);
        chk("cont_d_resp", d_resp, 1);
        chk("cont_i_resp_low", i_resp, 0);
        chk("cont_d_rdata", d_rdata, {R4, R3, R2, R1});
        d_read = 1'b0;
        step(1'b0, JUNK);
        chk("cont_idle_gap", pmem_read, 0);
        tick();
        chk("cont_i_granted", pmem_read, 1);
        chk("cont_i_addr", pmem_address, 32'h0000_3000);
        step(1'b1, S1);
        step(1'b0, JUNK);
        step(1'b0, JUNK);
        step(1'b1, S2);
        step(1'b1, S3);
        step(1'b0, JUNK);
        chk("gap_no_early_resp", i_resp, 0);
        chk("gap_still_reading", pmem_read, 1);
        step(1'b1, S4);
        chk("gap_i_resp", i_resp, 1);
        chk("gap_i_rdata", i_rdata, {S4, S3, S2, S1});
        chk("gap_d_rdata_kept", d_rdata, {R4, R3, R2, R1});
        i_read = 1'b0;
        step(1'b1, JUNK);
        step(1'b1, JUNK);
        chk("idle_resp_ignored_rd", pmem_read, 0);
        chk("idle_resp_ignored_wr", pmem_write, 0);
        chk("idle_resp_ignored_iresp", i_resp, 0);
        chk("idle_resp_ignored_dresp", d_resp, 0);
        pmem_resp = 1'b0;

        // ---------------- reset after beat 2 of a read ----------------
        i_read = 1'b1; i_address = 32'h0000_0040;
        tick();
        step(1'b1, JUNK);
        step(1'b1, JUNK);
        rst = 1'b1;
        step(1'b0, JUNK);
        chk("mid_rst_pmem_read", pmem_read, 0);
        chk("mid_rst_i_resp", i_resp, 0);
        chk("mid_rst_i_rdata", i_rdata, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_grant", pmem_read, 1);
        chk("post_rst_addr", pmem_address, 32'h0000_0040);
        step(1'b1, R1);
        step(1'b1, R2);
        step(1'b1, R3);
        step(1'b1, R4);
        chk("post_rst_i_resp", i_resp, 1);
        chk("post_rst_i_rdata", i_rdata, {R4, R3, R2, R1});
        i_read = 1'b0;
        step(1'b0, JUNK);

        // ---------------- back-to-back: writeback then read ----------------
        d_write = 1'b1; d_address = 32'h0000_0100; d_wdata = {WA, WB, WC, WD};
        tick();
        chk("b2b_wr_addr", pmem_address, 32'h0000_0100);
        step(1'b1, JUNK);
        step(1'b1, JUNK);
        step(1'b1, JUNK);
        step(1'b1, JUNK);
        chk("b2b_wr_resp", d_resp, 1);
        chk("b2b_gap1_quiet", {pmem_read, pmem_write}, 2'b00);
        d_write = 1'b0; d_read = 1'b1; d_address = 32'h0000_0200;
        step(1'b0, JUNK);
        chk("b2b_gap2_quiet", {pmem_read, pmem_write}, 2'b00);
        chk("b2b_no_resp_in_idle", d_resp, 0);
        tick();
        chk("b2b_rd_start", {pmem_read, pmem_write}, 2'b10);
        chk("b2b_rd_addr", pmem_address, 32'h0000_0200);
        step(1'b1, S4);
        step(1'b1, S3);
        step(1'b1, S2);
        step(1'b1, S1);
        chk("b2b_rd_resp", d_resp, 1);
        chk("b2b_rd_data", d_rdata, {S1, S2, S3, S4});
        d_read = 1'b0;
        step(1'b0, JUNK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pmem_arbiter.md
# pmem_arbiter

Sits between the split L1 caches and the single physical-memory port of `mp3`. It arbitrates cache-line requests from the instruction cache (read-only) and the data cache (read/write), and serialises each 256-bit line into four 64-bit beats on the burst `pmem_*` bus. It also reassembles read beats into a line and returns it with a single-cycle response.

## Interface
- No parameters. Line = 256 bits; beat = 64 bits; 4 beats per line.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_read` in 1: icache line-fill request, held until `i_resp`.
- `i_address` in 32: icache line address.
- `i_rdata` out 256: filled line for icache.
- `i_resp` out 1: one-cycle completion pulse to icache.
- `d_read` in 1: dcache line-fill request, held until `d_resp`.
- `d_write` in 1: dcache writeback request, held until `d_resp`.
- `d_address` in 32: dcache line address.
- `d_wdata` in 256: writeback line.
- `d_rdata` out 256: filled line for dcache.
- `d_resp` out 1: one-cycle completion pulse to dcache.
- `pmem_read` out 1: burst read request, held for the whole burst.
- `pmem_write` out 1: burst write request, held for the whole burst.
- `pmem_address` out 32: line address, bits [4:0] forced to 0.
- `pmem_wdata` out 64: current write beat.
- `pmem_rdata` in 64: current read beat, valid when `pmem_resp`.
- `pmem_resp` in 1: beat strobe, one beat per high cycle.

## Operation
- States:
  - IDLE: no request driven.
  - I_RD: icache fill in progress.
  - D_RD: dcache fill in progress.
  - D_WR: dcache writeback in progress.
  - DONE: one-cycle completion.
- Grant from IDLE, fixed priority: `d_write` > `d_read` > `i_read`.
  - `d_read` and `d_write` together is illegal; the write is served.
- At grant:
  - Latch the owner, address (bits [4:0] zeroed) and `d_wdata` into buffers.
  - Clear the 2-bit beat counter.
- Burst states:
  - `pmem_read` or `pmem_write` = 1; address comes from the latched buffer.
  - Each cycle with `pmem_resp`=1:
    - Read: store `pmem_rdata` into line buffer slice [64*beat +: 64].
    - Write: memory consumes `pmem_wdata` = wbuf[64*beat +: 64].
    - Then beat++.
  - Beat 0 is bits [63:0]; `pmem_wdata` is valid from the first burst cycle.
  - Beats need not be consecutive; cycles with `pmem_resp`=0 hold the counter.
  - On the 4th beat (beat==3 with `pmem_resp`), go to DONE; `pmem_read`/`pmem_write` drop in DONE.
- DONE:
  - Pulse the owner's resp for exactly one cycle.
  - Owner's rdata (read) equals the assembled line.
  - Next state is always IDLE, so requesters that deassert on resp are never re-granted.
- `i_rdata`/`d_rdata` are registered, held stable from DONE until that port's next fill completes. Both ports may share one line buffer only if the held value per port is preserved.
- `pmem_resp` while in IDLE or DONE is ignored.
- Input changes after grant (address, wdata) have no effect on the current burst.

## Timing
- Reset values:
  - All outputs 0: `pmem_read`, `pmem_write`, `pmem_address`, `pmem_wdata`, `i_resp`, `d_resp`, `i_rdata`, `d_rdata`.
  - State IDLE; beat counter 0.
- Cycle 0: request seen in IDLE. Cycle 1: `pmem_*` request asserted.
- With memory latency L (first beat at cycle 1+L, beats consecutive):
  - 4th beat at cycle 4+L.
  - resp at cycle 5+L.
  - Earliest next grant is evaluated at cycle 6+L.
- Minimum spacing between bursts: 2 idle `pmem` cycles (DONE, IDLE).
- Reset mid-burst: next cycle is IDLE with all outputs 0. The partial line is discarded, no resp is issued, and the counter is cleared.
- No combinational path from `pmem_*` inputs to any output.

## Test plan
- Icache fill: `i_read`, `i_address`=0x0000_0064, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → `pmem_address`=0x0000_0060; `i_rdata`={0x44..44, 0x33..33, 0x22..22, 0x11..11}; `i_resp` high exactly 1 cycle, 1 cycle after the 4th beat.
- Dcache writeback: `d_write`, `d_wdata`=256'h{D,C,B,A pattern} → `pmem_wdata` sequence A, B, C, D on successive `pmem_resp`; `d_resp` 1 cycle; `i_resp` stays 0.
- Contention: `i_read` and `d_read` asserted in the same cycle → dcache burst completes with `d_resp`, then icache burst starts; `i_rdata` is correct and `d_rdata` is unchanged after the icache fill.
- Gapped beats: `pmem_resp` pattern 1,0,0,1,1,0,1 → exactly 4 beats captured in order; resp after the last beat; `pmem_resp` pulse in IDLE causes no state change.
- Reset after beat 2 of a read → next cycle `pmem_read`=0 and no resp. A following `i_read` performs a full 4-beat burst with correct data.
- Back-to-back: dcache writeback then immediate `d_read` to a different line → two distinct bursts with correct addresses, separated by exactly 2 non-request cycles.
